// File: rtl/fpu_addsub_seq.sv
// Multi-cycle truncating floating-point add/subtract with a start/done handshake.
// Word format {sign, exp, man}: hidden leading one, bias 2^(EXP_W-1)-1, no denormals.
module fpu_addsub_seq #(
    parameter int EXP_W = 10,
    parameter int MAN_W = 21
) (
    input  logic                 clock_100Khz,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op_sub,
    input  logic [EXP_W+MAN_W:0] Op_A_in,
    input  logic [EXP_W+MAN_W:0] Op_B_in,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] data_out,
    output logic [3:0]           status_out
);
    localparam logic [EXP_W:0] EXP_MAX   = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] EXP_ONE   = (EXP_W+1)'(1);
    localparam logic [EXP_W:0] MAX_SHIFT = (EXP_W+1)'(MAN_W + 2);

    typedef enum logic [2:0] {IDLE, SWAP, ALIGN, ADD, NORM, DONE} state_t;
    state_t state;

    logic             sign_x, sign_y, sticky;
    logic [EXP_W:0]   exp_x;
    logic [EXP_W-1:0] exp_y;
    logic [MAN_W:0]   man_x, man_y;
    logic [MAN_W+1:0] sum;
    logic [EXP_W:0]   exp_diff;
    logic             y_larger;

    // exp_x carries one spare bit so a carry-out from the largest exponent is still visible.
    always_comb begin
        exp_diff = exp_x - {1'b0, exp_y};
        y_larger = {exp_y, man_y} > {exp_x[EXP_W-1:0], man_x};
    end

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_out   <= '0;
            status_out <= '0;
            sign_x     <= 1'b0;
            sign_y     <= 1'b0;
            sticky     <= 1'b0;
            exp_x      <= '0;
            exp_y      <= '0;
            man_x      <= '0;
            man_y      <= '0;
            sum        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_x <= Op_A_in[EXP_W+MAN_W];
                        exp_x  <= {1'b0, Op_A_in[EXP_W+MAN_W-1:MAN_W]};
                        man_x  <= {1'b1, Op_A_in[MAN_W-1:0]};
                        sign_y <= Op_B_in[EXP_W+MAN_W] ^ op_sub;
                        exp_y  <= Op_B_in[EXP_W+MAN_W-1:MAN_W];
                        man_y  <= {1'b1, Op_B_in[MAN_W-1:0]};
                        sticky <= 1'b0;
                        busy   <= 1'b1;
                        state  <= SWAP;
                    end
                end
                SWAP: begin
                    if (exp_x == '0 || exp_y == '0) begin
                        if (exp_y != '0)
                            data_out <= {sign_y, exp_y, man_y[MAN_W-1:0]};
                        else if (exp_x != '0)
                            data_out <= {sign_x, exp_x[EXP_W-1:0], man_x[MAN_W-1:0]};
                        else
                            data_out <= '0;
                        status_out <= 4'b0001;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        if (y_larger) begin
                            sign_x <= sign_y;
                            sign_y <= sign_x;
                            exp_x  <= {1'b0, exp_y};
                            exp_y  <= exp_x[EXP_W-1:0];
                            man_x  <= man_y;
                            man_y  <= man_x;
                        end
                        state <= ALIGN;
                    end
                end
                // A gap wider than the mantissa leaves only sticky, so skip the walk.
                ALIGN: begin
                    if (exp_diff == '0) begin
                        state <= ADD;
                    end else if (exp_diff > MAX_SHIFT) begin
                        sticky <= sticky | (|man_y);
                        man_y  <= '0;
                        exp_y  <= exp_x[EXP_W-1:0];
                    end else begin
                        sticky <= sticky | man_y[0];
                        man_y  <= man_y >> 1;
                        exp_y  <= exp_y + 1'b1;
                    end
                end
                ADD: begin
                    if (sign_x == sign_y)
                        sum <= {1'b0, man_x} + {1'b0, man_y};
                    else
                        sum <= {1'b0, man_x} - {1'b0, man_y};
                    state <= NORM;
                end
                NORM: begin
                    if (sum == '0) begin
                        data_out   <= '0;
                        status_out <= 4'b0001;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else if (sum[MAN_W+1]) begin
                        sum    <= sum >> 1;
                        sticky <= sticky | sum[0];
                        exp_x  <= exp_x + 1'b1;
                    end else if (sum[MAN_W]) begin
                        if (exp_x >= EXP_MAX) begin
                            data_out   <= {sign_x, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            status_out <= {sticky, 2'b01, 1'b0};
                        end else begin
                            data_out   <= {sign_x, exp_x[EXP_W-1:0], sum[MAN_W-1:0]};
                            status_out <= {sticky, 2'b00, !sticky};
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (exp_x <= EXP_ONE) begin
                        data_out   <= {sign_x, {(EXP_W+MAN_W){1'b0}}};
                        status_out <= 4'b1100;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        sum   <= sum << 1;
                        exp_x <= exp_x - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Self-checking bench for fpu_addsub_seq: directed cases plus randomized operands
// compared with an arithmetic truncating model, on the 10/21 and 8/23 formats.
module tb_fpu_addsub_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1, op_sub;
    logic [31:0] a_in, b_in;
    logic        busy0, done0, busy1, done1;
    logic [31:0] data0, data1;
    logic [3:0]  stat0, stat1;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fpu_addsub_seq #(.EXP_W(10), .MAN_W(21)) dut (
        .clock_100Khz(clk), .reset(rst_n), .start(start0), .op_sub(op_sub),
        .Op_A_in(a_in), .Op_B_in(b_in), .busy(busy0), .done(done0),
        .data_out(data0), .status_out(stat0)
    );

    fpu_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut_sp (
        .clock_100Khz(clk), .reset(rst_n), .start(start1), .op_sub(op_sub),
        .Op_A_in(a_in), .Op_B_in(b_in), .busy(busy1), .done(done1),
        .data_out(data1), .status_out(stat1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result of A op B as {status, word}: align by truncation, add, renormalise.
    function automatic logic [35:0] refModel(input int ew, input int mw, input logic [31:0] a,
                                             input logic [31:0] b, input logic sub);
        longint emask, mmask, ea, eb, ma, mb, ex, ey, xm, ym, s, e, d;
        logic   sa, sb, sx, sy, inex;
        emask = (longint'(1) << ew) - 1;
        mmask = (longint'(1) << mw) - 1;
        sa = a[31];
        sb = b[31] ^ sub;
        ea = (longint'(a) >> mw) & emask;
        eb = (longint'(b) >> mw) & emask;
        ma = longint'(a) & mmask;
        mb = longint'(b) & mmask;
        if (ea == 0 && eb == 0) return {4'b0001, 32'h0};
        if (ea == 0) return {4'b0001, sb, b[30:0]};
        if (eb == 0) return {4'b0001, a};
        if (eb > ea || (eb == ea && mb > ma)) begin
            sx = sb; ex = eb; xm = mb | (mmask + 1);
            sy = sa; ey = ea; ym = ma | (mmask + 1);
        end else begin
            sx = sa; ex = ea; xm = ma | (mmask + 1);
            sy = sb; ey = eb; ym = mb | (mmask + 1);
        end
        d = ex - ey;
        if (d > mw + 1) d = mw + 1;
        inex = (ym & ((longint'(1) << d) - 1)) != 0;
        ym = ym >> d;
        s = (sx == sy) ? xm + ym : xm - ym;
        e = ex;
        if (s == 0) return {4'b0001, 32'h0};
        if (s >= (longint'(2) << mw)) begin
            inex = inex | s[0];
            s = s >> 1;
            e = e + 1;
        end
        while (s < (longint'(1) << mw)) begin
            if (e <= 1) return {4'b1100, sx, 31'h0};
            s = s << 1;
            e = e - 1;
        end
        if (e >= emask) return {inex, 3'b010, 32'((longint'(sx) << 31) | (emask << mw))};
        return {inex, 2'b00, !inex, 32'((longint'(sx) << 31) | (e << mw) | (s & mmask))};
    endfunction

    function automatic logic [31:0] randOperand(input int ew, input int mw, input int centre);
        int     mode;
        longint e;
        mode = $urandom_range(0, 9);
        if (mode == 0) return {1'($urandom_range(0, 1)), 31'($urandom & ((32'h1 << mw) - 1))};
        if (mode == 1) return $urandom;
        e = longint'(centre) + longint'($urandom_range(0, 24)) - 12;
        if (e < 1) e = 1;
        if (e > (longint'(1) << ew) - 1) e = (longint'(1) << ew) - 1;
        return 32'((longint'($urandom_range(0, 1)) << 31) | (e << mw) |
                   (longint'($urandom) & ((longint'(1) << mw) - 1)));
    endfunction

    task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, output logic [31:0] res, output logic [3:0] st,
                                 output int cyc);
        logic d;
        a_in = a;
        b_in = b;
        op_sub = sub;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        cyc = 1;
        checkOutput("busy_after_start", (sel == 0) ? busy0 : busy1, 1'b1);
        d = (sel == 0) ? done0 : done1;
        while (!d && cyc < 200) begin
            @(negedge clk);
            cyc++;
            d = (sel == 0) ? done0 : done1;
        end
        checkOutput("done_seen", d, 1'b1);
        res = (sel == 0) ? data0 : data1;
        st  = (sel == 0) ? stat0 : stat1;
        @(negedge clk);
        checkOutput("done_one_cycle", (sel == 0) ? done0 : done1, 1'b0);
    endtask

    task automatic runCase(input string tag, input int sel, input logic [31:0] a,
                           input logic [31:0] b, input logic sub,
                           input logic [31:0] exp_data, input logic [3:0] exp_stat);
        logic [31:0] res;
        logic [3:0]  st;
        int          cyc;
        applyStimulus(sel, a, b, sub, res, st, cyc);
        checkOutput({tag, "_data"}, res, exp_data);
        checkOutput({tag, "_status"}, st, exp_stat);
    endtask

    initial begin
        logic [31:0] res, a, b;
        logic [3:0]  st;
        logic [35:0] model;
        int          cyc, done_hits, sel, ew, mw, bias;
        logic        sub;

        rst_n = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        op_sub = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy0, 1'b0);
        checkOutput("reset_done", done0, 1'b0);
        checkOutput("reset_data", data0, 32'h0);
        checkOutput("reset_status", stat0, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);

        runCase("two_plus_one", 0, 32'h40000000, 32'h3FE00000, 1'b0, 32'h40100000, 4'b0001);

        // Abort an operation in the middle of alignment.
        a_in = 32'h41200000;
        b_in = 32'h3FE00000;
        op_sub = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("busy_before_reset", busy0, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midop_reset_busy", busy0, 1'b0);
        checkOutput("midop_reset_data", data0, 32'h0);
        checkOutput("midop_reset_status", stat0, 4'h0);
        done_hits = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0) done_hits++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done0) done_hits++;
        end
        checkOutput("midop_reset_no_done", done_hits, 0);
        runCase("after_reset", 0, 32'h40000000, 32'h3FE00000, 1'b0, 32'h40100000, 4'b0001);

        // Back-to-back: second start lands in the idle cycle right after done.
        runCase("sub_7_3", 0, 32'h40380000, 32'h40100000, 1'b1, 32'h40200000, 4'b0001);
        runCase("cancel", 0, 32'h40400000, 32'hC0400000, 1'b0, 32'h00000000, 4'b0001);
        runCase("large_shift", 0, 32'h41200000, 32'h3FE00000, 1'b0, 32'h41200800, 4'b0001);
        runCase("inexact", 0, 32'h3FE00000, 32'h3D200000, 1'b0, 32'h3FE00000, 4'b1000);
        runCase("overflow", 0, 32'h7FC00000, 32'h7FC00000, 1'b0, 32'h7FE00000, 4'b0010);
        runCase("underflow", 0, 32'h00200001, 32'h00200000, 1'b1, 32'h00000000, 4'b1100);
        runCase("both_zero", 0, 32'h80000000, 32'h00012345, 1'b0, 32'h00000000, 4'b0001);

        applyStimulus(0, 32'h40100000, 32'h00000000, 1'b0, res, st, cyc);
        checkOutput("zero_b_data", res, 32'h40100000);
        checkOutput("zero_b_fast", cyc <= 4, 1'b1);
        applyStimulus(0, 32'h00000000, 32'h40100000, 1'b1, res, st, cyc);
        checkOutput("zero_a_sub_data", res, 32'hC0100000);
        applyStimulus(0, 32'h3FE00000, 32'h3FE00000, 1'b0, res, st, cyc);
        checkOutput("one_plus_one_data", res, 32'h40000000);
        checkOutput("one_plus_one_latency", cyc, 6);

        // A start while busy must neither resample the inputs nor queue a second result.
        a_in = 32'h40000000;
        b_in = 32'h3FE00000;
        op_sub = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        a_in = 32'h7FC00000;
        b_in = 32'h7FC00000;
        op_sub = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 0;
        while (!done0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("ignored_start_done", done0, 1'b1);
        checkOutput("ignored_start_data", data0, 32'h40100000);
        checkOutput("ignored_start_status", stat0, 4'b0001);
        done_hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0) done_hits++;
        end
        checkOutput("ignored_start_no_second", done_hits, 0);

        runCase("sp_one_plus_two", 1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0001);

        for (int i = 0; i < 60; i++) begin
            sel  = (i % 3 == 2) ? 1 : 0;
            ew   = (sel == 1) ? 8 : 10;
            mw   = (sel == 1) ? 23 : 21;
            bias = (1 << (ew - 1)) - 1;
            a    = randOperand(ew, mw, bias);
            if ($urandom_range(0, 4) == 0) b = a ^ ($urandom & 32'h000000FF);
            else b = randOperand(ew, mw, bias);
            sub   = 1'($urandom_range(0, 1));
            model = refModel(ew, mw, a, b, sub);
            applyStimulus(sel, a, b, sub, res, st, cyc);
            checkOutput((sel == 1) ? "rand_sp_data" : "rand_data", res, model[31:0]);
            checkOutput((sel == 1) ? "rand_sp_status" : "rand_status", st, model[35:32]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fpu_addsub_seq.md
Name: fpu_addsub_seq

Overview:
Parametrised, multi-cycle floating-point add/subtract unit. It is the successor to the fixed 1/10/21 FPU adder and generalises the exponent and mantissa widths. It adds a subtract mode, a start/done handshake and truncation with an inexact flag. It sits in the same datapath as the current FPU and runs on the 100 kHz system clock. The default parameters reproduce the existing 32-bit format.

Parameters:
EXP_W, 10, exponent field width; bias = 2^(EXP_W-1)-1 (511 by default)
MAN_W, 21, stored mantissa width; hidden leading 1 is implied
(word width W = 1+EXP_W+MAN_W, 32 by default)

Ports:
clock_100Khz  in   1  system clock; single clock domain
reset         in   1  asynchronous, active-low reset
start         in   1  one-cycle request; captures op_a, op_b, op_sub
op_sub        in   1  0: A+B, 1: A-B (sign of B is inverted at capture)
Op_A_in       in   W  operand A {sign, exp, man}
Op_B_in       in   W  operand B
busy          out  1  high from the cycle after start until done
done          out  1  one-cycle pulse; data_out/status_out valid from this cycle
data_out      out  W  result, held until the next done
status_out    out  4  [0] exact, [1] overflow, [2] underflow, [3] inexact; held with data_out

Behaviour:
- Format: exp==0 means zero (mantissa ignored); no denormals. exp all-ones means infinity on output only; an all-ones exp on an input is treated as finite.
- Reset (reset=0, async): state IDLE; busy=0, done=0, data_out=0, status_out=0. Reset mid-operation aborts the operation with no done pulse.
- start is honoured only in IDLE. While busy, start is ignored and the inputs are not re-sampled.
- FSM:
  - IDLE: on start, capture operands; signB ^= op_sub; go to SWAP.
  - SWAP (1 cycle): order so |X| >= |Y| by {exp, man}. If either operand is zero, go to DONE with the other operand as the result; if both are zero the result is +0.
  - ALIGN: shift Y right by 1 per cycle, incrementing exp_Y, until exp_Y == exp_X. Shifted-out bits OR into a sticky bit. If diff > MAN_W+2, Y collapses to sticky in one cycle.
  - ADD (1 cycle): add or subtract the MAN_W+2-bit magnitudes (hidden bit plus carry) by sign equality; result sign = sign of X.
  - NORM: on carry-out, shift right 1 and exp+1 (1 cycle). Otherwise shift left 1 per cycle, exp-1, until the hidden bit is set. A zero magnitude goes straight to DONE with +0 (sign 0) and exact.
  - DONE: register data_out/status_out, pulse done, return to IDLE.
- Latency: 5 cycles minimum (start→done) for equal exponents with no normalisation. Worst case is about 2*MAN_W+6 cycles.
- Rounding: truncate toward zero. Inexact is set if any sticky or shifted-out bit was nonzero. Exact = !inexact && !overflow && !underflow.
- Overflow: when the normalised exp reaches 2^EXP_W-1, output {sign, all-ones, 0}; overflow=1.
- Underflow: when the normalised exp would drop to <=0, output signed zero; underflow=1, inexact=1.
- A new start is accepted in the cycle after done (back-to-back is allowed).

Test Plan:
- Reset: assert reset=0 mid-ALIGN → busy=0, done never pulses, data_out=0; after release, start 0x40000000+0x3FE00000 → data_out 0x40100000 (3.0), status 4'b0001.
- Subtract mode: op_sub=1, A=0x40380000 (7.0), B=0x40100000 (3.0) → 0x40200000 (4.0), exact. Cancellation: 0x40400000 + 0xC0400000 → 0x00000000, exact.
- Zero operand: 0x40100000 + 0x00000000 → 0x40100000 in <=4 cycles. Large shift: 1024.0 (0x41200000) + 1.0 → 0x41200800 (1025.0), exact.
- Inexact: 0x3FE00000 + 0x3D200000 (2^-22) → 0x3FE00000, status 4'b1000. Overflow: 0x7FC00000 + 0x7FC00000 → 0x7FE00000, status 4'b0010.
- Handshake: start pulsed while busy → ignored, first result intact. start issued the cycle after done → accepted; done pulses are exactly 1 cycle.
- Parameter sweep: EXP_W=8, MAN_W=23 → 1.0+2.0 = 0x40400000; random add/sub checked against a truncating reference model.
